reg_file_mp: RTL and testbench

- Parametrised successor to the single-write-port pipeline register file.
- Adds a second write port, a per-register busy scoreboard for hazard detection, and a sequential post-reset clear engine.
- Optional same-cycle write-to-read bypass.
- Sits between decode (read, issue) and writeback (two retire lanes) in the pipelined core.

---
 rtl/reg_file_mp_if.sv | 45 ++++
 rtl/reg_file_mp.sv | 182 ++++++++++++++++++
 tb/tb_reg_file_mp.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: bundles the read, write, issue and scoreboard signals of reg_file_mp.
// master = decode/writeback side driving requests, slave = the register file.
interface reg_file_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic              ready;
   logic              wen0;
   logic [ADDR_W-1:0] waddr0;
   logic [DATA_W-1:0] wdata0;
   logic              wen1;
   logic [ADDR_W-1:0] waddr1;
   logic [DATA_W-1:0] wdata1;
   logic [ADDR_W-1:0] raddr1;
   logic [ADDR_W-1:0] raddr2;
   logic [DATA_W-1:0] rdata1;
   logic [DATA_W-1:0] rdata2;
   logic              iss_en;
   logic [ADDR_W-1:0] iss_addr;
   logic              rbusy1;
   logic              rbusy2;
   logic [DEPTH-1:0]  busy_vec;

   modport master (
      input  ready,
      output wen0, waddr0, wdata0,
      output wen1, waddr1, wdata1,
      output raddr1, raddr2,
      input  rdata1, rdata2,
      output iss_en, iss_addr,
      input  rbusy1, rbusy2, busy_vec
   );

   modport slave (
      output ready,
      input  wen0, waddr0, wdata0,
      input  wen1, waddr1, wdata1,
      input  raddr1, raddr2,
      output rdata1, rdata2,
      input  iss_en, iss_addr,
      output rbusy1, rbusy2, busy_vec
   );
endinterface

// File: rtl/reg_file_mp.sv
// reg_file_mp: 2-write/2-read register file with busy scoreboard and post-reset clear.
// Ports: clk, rst (sync active-high), bus (reg_file_mp_if.slave). Option: REG_FILE_MP_BYPASS_EN.
module reg_file_mp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic           clk,
   input  logic           rst,
   reg_file_mp_if.slave   bus
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {
      INIT,
      RUN
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] clr_ptr_q;
   logic [ADDR_W-1:0] clr_ptr_d;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;
   logic              run;
   logic              we0_ok;
   logic              we1_ok;

   assign run = (state_q == RUN);

   // ---------------- clear sequencer ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= INIT;
         clr_ptr_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      unique case (state_q)
         INIT: begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == ADDR_W'(DEPTH - 1))
               state_d = RUN;
         end
         RUN: begin
            state_d = RUN;
         end
         default: begin
            state_d = INIT;
         end
      endcase
   end

   // ---------------- array write ----------------
   // Port 0 is suppressed when port 1 hits the same entry,
   // so port 1 always owns a shared address.
   assign we1_ok = run && bus.wen1 && (bus.waddr1 != '0);
   assign we0_ok = run && bus.wen0 && (bus.waddr0 != '0) &&
                   !(bus.wen1 && (bus.waddr1 == bus.waddr0));

   // Array is not reset; INIT walks it to zero instead.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == INIT) begin
            mem[clr_ptr_q] <= '0;
         end else begin
            if (we0_ok)
               mem[bus.waddr0] <= bus.wdata0;
            if (we1_ok)
               mem[bus.waddr1] <= bus.wdata1;
         end
      end
   end

   // ---------------- scoreboard ----------------
   // A new issue beats a retiring write to the same register.
   always_comb begin
      busy_d = busy_q;
      if (run) begin
         for (int i = 1; i < DEPTH; i++) begin
            if (bus.iss_en && (bus.iss_addr == ADDR_W'(i)))
               busy_d[i] = 1'b1;
            else if ((bus.wen0 && (bus.waddr0 == ADDR_W'(i))) ||
                     (bus.wen1 && (bus.waddr1 == ADDR_W'(i))))
               busy_d[i] = 1'b0;
         end
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst)
         busy_q <= '0;
      else
         busy_q <= busy_d;
   end

   // ---------------- read ports ----------------
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;
   logic              rb1;
   logic              rb2;

`ifdef REG_FILE_MP_BYPASS_EN
   logic hit1_w0;
   logic hit1_w1;
   logic hit2_w0;
   logic hit2_w1;
   logic iss1;
   logic iss2;

   assign hit1_w1 = bus.wen1 && (bus.waddr1 == bus.raddr1);
   assign hit1_w0 = bus.wen0 && (bus.waddr0 == bus.raddr1);
   assign hit2_w1 = bus.wen1 && (bus.waddr1 == bus.raddr2);
   assign hit2_w0 = bus.wen0 && (bus.waddr0 == bus.raddr2);
   assign iss1    = bus.iss_en && (bus.iss_addr == bus.raddr1);
   assign iss2    = bus.iss_en && (bus.iss_addr == bus.raddr2);

   always_comb begin
      rd1 = '0;
      rb1 = 1'b0;
      if (run && (bus.raddr1 != '0)) begin
         rd1 = mem[bus.raddr1];
         rb1 = busy_q[bus.raddr1];
         if (hit1_w1 || hit1_w0)
            rb1 = iss1;
         if (hit1_w1)
            rd1 = bus.wdata1;
         else if (hit1_w0)
            rd1 = bus.wdata0;
      end
   end

   always_comb begin
      rd2 = '0;
      rb2 = 1'b0;
      if (run && (bus.raddr2 != '0)) begin
         rd2 = mem[bus.raddr2];
         rb2 = busy_q[bus.raddr2];
         if (hit2_w1 || hit2_w0)
            rb2 = iss2;
         if (hit2_w1)
            rd2 = bus.wdata1;
         else if (hit2_w0)
            rd2 = bus.wdata0;
      end
   end
`else
   always_comb begin
      rd1 = '0;
      rb1 = 1'b0;
      if (run && (bus.raddr1 != '0)) begin
         rd1 = mem[bus.raddr1];
         rb1 = busy_q[bus.raddr1];
      end
   end

   always_comb begin
      rd2 = '0;
      rb2 = 1'b0;
      if (run && (bus.raddr2 != '0)) begin
         rd2 = mem[bus.raddr2];
         rb2 = busy_q[bus.raddr2];
      end
   end
`endif

   assign bus.rdata1   = rd1;
   assign bus.rdata2   = rd2;
   assign bus.rbusy1   = rb1;
   assign bus.rbusy2   = rb2;
   assign bus.busy_vec = busy_q;
   assign bus.ready    = run;

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed stimulus with a per-cycle reference model and literal checks.
// Build with or without REG_FILE_MP_BYPASS_EN; expectations follow the same macro.
module tb_reg_file_mp;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   reg_file_mp_if bus ();

   reg_file_mp dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_mem [32];
   logic [31:0] m_busy = '0;
   bit          m_rdy  = 1'b0;
   int          m_cnt  = 0;
   bit          m_en   = 1'b0;

   initial
      for (int i = 0; i < 32; i++)
         m_mem[i] = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_en   <= 1'b1;
         m_rdy  <= 1'b0;
         m_cnt  <= 0;
         m_busy <= '0;
      end else if (!m_rdy) begin
         // Clearing takes 32 cycles; model it as one wholesale wipe at the end.
         m_cnt <= m_cnt + 1;
         if (m_cnt == 31) begin
            m_rdy <= 1'b1;
            for (int i = 0; i < 32; i++)
               m_mem[i] <= '0;
         end
      end else begin
         if (bus.wen0 && bus.waddr0 != 0)
            m_mem[bus.waddr0] <= bus.wdata0;
         if (bus.wen1 && bus.waddr1 != 0)
            m_mem[bus.waddr1] <= bus.wdata1;
         for (int i = 1; i < 32; i++) begin
            if (bus.iss_en && bus.iss_addr == i)
               m_busy[i] <= 1'b1;
            else if ((bus.wen0 && bus.waddr0 == i) ||
                     (bus.wen1 && bus.waddr1 == i))
               m_busy[i] <= 1'b0;
         end
      end
   end

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (!m_rdy || a == 0)
         return '0;
`ifdef REG_FILE_MP_BYPASS_EN
      if (bus.wen1 && bus.waddr1 == a)
         return bus.wdata1;
      if (bus.wen0 && bus.waddr0 == a)
         return bus.wdata0;
`endif
      return m_mem[a];
   endfunction

   function automatic logic exp_rb(input logic [4:0] a);
      if (!m_rdy || a == 0)
         return 1'b0;
`ifdef REG_FILE_MP_BYPASS_EN
      if ((bus.wen1 && bus.waddr1 == a) || (bus.wen0 && bus.waddr0 == a))
         return bus.iss_en && bus.iss_addr == a;
`endif
      return m_busy[a];
   endfunction

   always @(negedge clk) begin
      if (m_en) begin
         chk("m_ready", 64'(bus.ready), 64'(m_rdy));
         chk("m_rdata1", 64'(bus.rdata1), 64'(exp_rd(bus.raddr1)));
         chk("m_rdata2", 64'(bus.rdata2), 64'(exp_rd(bus.raddr2)));
         chk("m_rbusy1", 64'(bus.rbusy1), 64'(exp_rb(bus.raddr1)));
         chk("m_rbusy2", 64'(bus.rbusy2), 64'(exp_rb(bus.raddr2)));
         chk("m_busy_vec", 64'(bus.busy_vec), 64'(m_busy));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.wen0     = 1'b0;
      bus.wen1     = 1'b0;
      bus.iss_en   = 1'b0;
      bus.waddr0   = '0;
      bus.waddr1   = '0;
      bus.wdata0   = '0;
      bus.wdata1   = '0;
      bus.iss_addr = '0;
   endtask

   // Counts sample points (posedge+1) with ready low; drops all
   // write/issue activity the moment ready is seen.
   task automatic wait_ready(output int lows);
      lows = 0;
      while (!bus.ready && lows < 100) begin
         lows++;
         tick();
      end
      if (!bus.ready)
         chk("ready_timeout", 64'(bus.ready), 64'd1);
      idle();
   endtask

   int lows;

   initial begin
      idle();
      bus.raddr1 = '0;
      bus.raddr2 = '0;
      rst = 1'b1;
      tick();
      tick();
      chk("reset_ready", 64'(bus.ready), 64'd0);
      chk("reset_busy", 64'(bus.busy_vec), 64'd0);
      rst = 1'b0;
      wait_ready(lows);
      chk("first_init_len", 64'(lows), 64'd32);

      // Preload 1..31 with all ones, then reset and expect zeros.
      for (int a = 1; a < 32; a++) begin
         bus.wen0   = 1'b1;
         bus.waddr0 = 5'(a);
         bus.wdata0 = 32'hFFFF_FFFF;
         tick();
      end
      idle();
      bus.raddr1 = 5'd31;
      bus.raddr2 = 5'd1;
      #1;
      chk("preload_31", 64'(bus.rdata1), 64'h0000_0000_FFFF_FFFF);
      chk("preload_1", 64'(bus.rdata2), 64'h0000_0000_FFFF_FFFF);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_ready(lows);
      chk("clear_init_len", 64'(lows), 64'd32);
      for (int a = 0; a < 32; a++) begin
         bus.raddr1 = 5'(a);
         bus.raddr2 = 5'(31 - a);
         #1;
         chk("clear_rd1", 64'(bus.rdata1), 64'd0);
         chk("clear_rd2", 64'(bus.rdata2), 64'd0);
      end

      // Dual write to the same register: port 1 wins.
      bus.wen0   = 1'b1;
      bus.waddr0 = 5'd7;
      bus.wdata0 = 32'hAAAA_0000;
      bus.wen1   = 1'b1;
      bus.waddr1 = 5'd7;
      bus.wdata1 = 32'h5555_FFFF;
      tick();
      idle();
      bus.raddr1 = 5'd7;
      #1;
      chk("dual_write", 64'(bus.rdata1), 64'h5555_FFFF);

      // Distinct addresses on both ports in one cycle.
      bus.wen0   = 1'b1;
      bus.waddr0 = 5'd12;
      bus.wdata0 = 32'h0000_1212;
      bus.wen1   = 1'b1;
      bus.waddr1 = 5'd13;
      bus.wdata1 = 32'h0000_1313;
      tick();
      idle();
      bus.raddr1 = 5'd12;
      bus.raddr2 = 5'd13;
      #1;
      chk("dual_p0", 64'(bus.rdata1), 64'h1212);
      chk("dual_p1", 64'(bus.rdata2), 64'h1313);

      // Register zero is hardwired.
      bus.wen1     = 1'b1;
      bus.waddr1   = 5'd0;
      bus.wdata1   = 32'h1234_5678;
      bus.iss_en   = 1'b1;
      bus.iss_addr = 5'd0;
      tick();
      idle();
      bus.raddr1 = 5'd0;
      #1;
      chk("zero_read", 64'(bus.rdata1), 64'd0);
      chk("zero_busy", 64'(bus.busy_vec[0]), 64'd0);

      // Scoreboard: set, set-beats-clear, then clear.
      bus.iss_en   = 1'b1;
      bus.iss_addr = 5'd3;
      tick();
      idle();
      bus.raddr2 = 5'd3;
      #1;
      chk("sb_set", 64'(bus.busy_vec[3]), 64'd1);
      chk("sb_rbusy2", 64'(bus.rbusy2), 64'd1);
      bus.raddr2   = 5'd0;
      bus.iss_en   = 1'b1;
      bus.iss_addr = 5'd3;
      bus.wen0     = 1'b1;
      bus.waddr0   = 5'd3;
      bus.wdata0   = 32'h3;
      tick();
      idle();
      #1;
      chk("sb_race", 64'(bus.busy_vec[3]), 64'd1);
      bus.wen0   = 1'b1;
      bus.waddr0 = 5'd3;
      bus.wdata0 = 32'h33;
      tick();
      idle();
      #1;
      chk("sb_clear", 64'(bus.busy_vec), 64'd0);

      // Same-cycle write/read of register 9.
      bus.wen0   = 1'b1;
      bus.waddr0 = 5'd9;
      bus.wdata0 = 32'h1111_1111;
      tick();
      bus.wdata0 = 32'hDEAD_BEEF;
      bus.raddr2 = 5'd9;
      #1;
`ifdef REG_FILE_MP_BYPASS_EN
      chk("bypass_same", 64'(bus.rdata2), 64'hDEAD_BEEF);
`else
      chk("bypass_same", 64'(bus.rdata2), 64'h1111_1111);
`endif
      tick();
      idle();
      #1;
      chk("bypass_next", 64'(bus.rdata2), 64'hDEAD_BEEF);

      // Reset in the middle of clearing, with traffic held active.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.wen0     = 1'b1;
      bus.waddr0   = 5'd30;
      bus.wdata0   = 32'hCAFE_0030;
      bus.wen1     = 1'b1;
      bus.waddr1   = 5'd2;
      bus.wdata1   = 32'hCAFE_0002;
      bus.iss_en   = 1'b1;
      bus.iss_addr = 5'd6;
      repeat (10) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_ready(lows);
      chk("midinit_len", 64'(lows), 64'd32);
      bus.raddr1 = 5'd30;
      bus.raddr2 = 5'd2;
      #1;
      chk("midinit_rd30", 64'(bus.rdata1), 64'd0);
      chk("midinit_rd2", 64'(bus.rdata2), 64'd0);
      chk("midinit_busy", 64'(bus.busy_vec), 64'd0);
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
